// File: rtl/microtile_pkg.sv
// microtile_pkg: shared pin-field indices and parameter limits
// for the microtile PWM bank.
package microtile_pkg;

  localparam int WR_BIT   = 7;
  localparam int NIB_BIT  = 6;
  localparam int CH_LSB   = 4;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 4;
  localparam int TICK_BIT = 7;

  localparam int MAX_CH       = 4;
  localparam int MIN_CNT_W    = 4;
  localparam int MAX_CNT_W    = 8;
  localparam int MAX_PRESCALE = 256;

endpackage

// File: rtl/microtile_sync_edge.sv
// microtile_sync_edge: W-bit 2-FF synchroniser with rising-edge
// detect on bit EDGE_BIT of the synchronised bus.
module microtile_sync_edge #(
  parameter int W        = 8,
  parameter int EDGE_BIT = W - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise
);

  logic [W-1:0] s1;
  logic         s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
      s3 <= q[EDGE_BIT];
    end
  end

  assign rise = q[EDGE_BIT] & ~s3;

endmodule

// File: rtl/microtile_pwm_bank.sv
// microtile_pwm_bank: NUM_CH shadow-loaded PWM channels with period tick.
// Define MICROTILE_PWM_PHASE_EN to stagger channel phases.
module microtile_pwm_bank #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  import microtile_pkg::*;

  localparam int CH_W  = $clog2(MAX_CH);
  localparam int PRE_W = $clog2(MAX_PRESCALE);
`ifdef MICROTILE_PWM_PHASE_EN
  localparam bit PHASE_EN = 1'b1;
`else
  localparam bit PHASE_EN = 1'b0;
`endif

  logic [7:0]        sync;
  logic              rise;
  logic              wr;
  logic              wr_hi;
  logic [CH_W-1:0]   wr_ch;
  logic [DATA_W-1:0] wr_data;

  logic [PRE_W-1:0] pre;
  logic             tick;
  logic             boundary;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cmp;
  logic [7:0]       out_d;

  logic [CNT_W-1:0] pending [NUM_CH];
  logic [CNT_W-1:0] active  [NUM_CH];

  microtile_sync_edge #(
    .W        (8),
    .EDGE_BIT (WR_BIT)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (ui_in),
    .q    (sync),
    .rise (rise)
  );

  assign wr      = rise & sync[WR_BIT];
  assign wr_hi   = sync[NIB_BIT];
  assign wr_ch   = sync[CH_LSB +: CH_W];
  assign wr_data = sync[DATA_LSB +: DATA_W];

  assign tick     = (pre == PRE_W'(PRESCALE - 1));
  assign boundary = tick && (cnt == '1);

  // High-nibble bits beyond CNT_W fall off in the final truncation.
  function automatic logic [CNT_W-1:0] merge(
    input logic [CNT_W-1:0]  old,
    input logic              hi,
    input logic [DATA_W-1:0] nib
  );
    logic [MAX_CNT_W-1:0] w;
    w = MAX_CNT_W'(old);
    if (hi) w[DATA_W +: DATA_W] = nib;
    else    w[0 +: DATA_W]      = nib;
    return w[CNT_W-1:0];
  endfunction

  always_comb begin
    out_d = '0;
    cmp   = '0;
    out_d[TICK_BIT] = boundary;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp = cnt + (PHASE_EN ? CNT_W'((i << CNT_W) / NUM_CH) : '0);
      out_d[i] = (cmp < active[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre    <= '0;
      cnt    <= '0;
      uo_out <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      pre    <= tick ? '0 : pre + 1'b1;
      uo_out <= out_d;
      if (tick) cnt <= cnt + 1'b1;
      // Shadow load reads the pre-write pending value on a shared edge.
      for (int i = 0; i < NUM_CH; i++) begin
        if (boundary) active[i] <= pending[i];
        if (wr && wr_ch == CH_W'(i)
            && !(wr_hi && CNT_W <= MIN_CNT_W))
          pending[i] <= merge(pending[i], wr_hi, wr_data);
      end
    end
  end

endmodule

// File: tb/tb_microtile_pwm_bank.sv
// tb_microtile_pwm_bank: two configurations driven from one pin bus,
// each checked every clock against an arithmetic period model.
module tb_microtile_pwm_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uo0;
  logic [7:0] uo1;

  always #5 clk = ~clk;

  microtile_pwm_bank dut0 (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo0)
  );

  microtile_pwm_bank #(
    .NUM_CH   (2),
    .CNT_W    (4),
    .PRESCALE (3)
  ) dut1 (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo1)
  );

`ifdef MICROTILE_PWM_PHASE_EN
  localparam bit PH = 1'b1;
`else
  localparam bit PH = 1'b0;
`endif

  int nch [2] = '{4, 2};
  int wid [2] = '{8, 4};
  int psc [2] = '{1, 3};

  int         t    [2];
  int         pend [2][4];
  int         act  [2][4];
  logic [7:0] exp_o [2];
  logic [7:0] h1, h2, h3;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h (t0=%0d)",
               tag, got, want, t[0]);
    end
  endtask

  function automatic int off(input int d, input int i);
    return PH ? (i << wid[d]) / nch[d] : 0;
  endfunction

  // Reference: clocks since reset give counter and boundaries directly.
  task automatic model_edge();
    logic       wr;
    logic [7:0] s;
    int j, m, cb, c;
    logic [7:0] e;
    bit bnd;
    if (rst) begin
      h1 = '0; h2 = '0; h3 = '0;
      for (int d = 0; d < 2; d++) begin
        t[d] = 0;
        exp_o[d] = '0;
        for (int i = 0; i < 4; i++) begin
          pend[d][i] = 0;
          act[d][i]  = 0;
        end
      end
      return;
    end
    wr = h2[7] && !h3[7];
    s  = h2;
    h3 = h2; h2 = h1; h1 = ui_in;
    for (int d = 0; d < 2; d++) begin
      t[d]++;
      j   = t[d];
      m   = 1 << wid[d];
      cb  = ((j - 1) / psc[d]) % m;
      bnd = (j % psc[d] == 0) && ((j / psc[d]) % m == 0);
      e = '0;
      e[7] = bnd;
      for (int i = 0; i < nch[d]; i++)
        e[i] = ((cb + off(d, i)) % m) < act[d][i];
      if (bnd)
        for (int i = 0; i < 4; i++) act[d][i] = pend[d][i];
      c = int'(s[5:4]);
      if (wr && c < nch[d]) begin
        if (!s[6])
          pend[d][c] = (pend[d][c] & ~15) | int'(s[3:0]);
        else if (wid[d] > 4)
          pend[d][c] = (int'(s[3:0]) * 16 + (pend[d][c] & 15)) % m;
      end
      exp_o[d] = e;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk(rst ? "rst_a" : "out_a", uo0, exp_o[0]);
    chk(rst ? "rst_b" : "out_b", uo1, exp_o[1]);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_ph(input int n);
    for (int k = 0; k < 300 && (t[0] % 256) != n; k++) cyc();
    chk("wait_ph", 8'(t[0] % 256), 8'(n));
  endtask

  task automatic wr_nib(input int ch, input bit hi,
                        input logic [3:0] nib, input int hold);
    ui_in = {1'b0, hi, 2'(ch), nib};
    run(3);
    ui_in[7] = 1'b1;
    run(hold);
    ui_in[7] = 1'b0;
    run(3);
  endtask

  task automatic wr_duty(input int ch, input logic [7:0] v,
                         input int hold);
    wr_nib(ch, 1'b0, v[3:0], hold);
    wr_nib(ch, 1'b1, v[7:4], hold);
  endtask

  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;

    wr_duty(0, 8'h40, 2);
    run(600);

    wr_duty(1, 8'h00, 2);
    wr_duty(2, 8'hFF, 2);
    wr_duty(3, 8'h0B, 2);
    run(600);

    wait_ph(8'h70);
    wr_duty(0, 8'hC0, 1);
    run(600);

    ui_in = {1'b0, 1'b1, 2'd0, 4'h2};
    run(3);
    wait_ph(253);
    ui_in[7] = 1'b1;
    run(4);
    ui_in[7] = 1'b0;
    run(700);

    wr_nib(1, 1'b0, 4'h9, 20);
    ui_in = {1'b0, 1'b0, 2'd2, 4'h5};
    run(3);
    ui_in[7] = 1'b1;
    run(5);
    ui_in[3:0] = 4'hE;
    run(5);
    ui_in[7] = 1'b0;
    run(3);
    wr_nib(3, 1'b0, 4'h7, 2);
    wr_nib(0, 1'b1, 4'hF, 2);
    run(800);

    wait_ph(8'h30);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run(600);

    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end else if (r < 3) begin
        repeat (6) begin
          ui_in = 8'($urandom);
          cyc();
        end
        ui_in = '0;
        run(3);
      end else if (r < 10) begin
        wr_duty($urandom_range(0, 3), 8'($urandom),
                $urandom_range(1, 6));
      end else begin
        wr_nib($urandom_range(0, 3), 1'($urandom),
               4'($urandom), $urandom_range(1, 6));
      end
      run($urandom_range(1, 300));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/microtile_pwm_bank.md
Name: microtile_pwm_bank

Overview:
Parametrised multi-channel PWM microtile, the sequential successor to the combinational ui_in→uo_out Wokwi tile.
- Duty values are written nibble-wise through ui_in using a strobe protocol.
- Outputs are NUM_CH glitch-free PWM streams plus a period tick on uo_out.
- Sits as a standalone tile behind the standard TinyTapeout pin wrapper.

Parameters:
- NUM_CH, 4, number of PWM channels (1..4).
- CNT_W, 8, PWM counter/duty width in bits (4..8); period = 2^CNT_W ticks.
- PRESCALE, 1, clocks per counter tick (1..256).

Ports:
- clk  input  1  tile clock.
- rst  input  1  reset: synchronous, active-high.
- ui_in  input  8  async pins.
  - [7] write strobe.
  - [6] nibble select (0 = duty[3:0], 1 = duty[CNT_W-1:4]).
  - [5:4] channel select.
  - [3:0] data nibble.
- uo_out  output  8  outputs.
  - [NUM_CH-1:0] PWM outputs.
  - [7] period tick, 1 clk wide.
  - All other bits 0.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Synchroniser, counter, prescaler, pending and active duty registers all cleared.
  - uo_out=0 from the next edge.
  - Reset mid-period or mid-write discards all state; no partial write survives.
- Input sync:
  - All 8 ui_in bits pass through a 2-FF synchroniser.
  - A third FF on the strobe gives rising-edge detect.
  - A write commits to duty_pending on the 3rd clk edge after ui_in[7] rises.
  - ui_in[6:0] must be stable ≥3 clk before the strobe and until it falls.
- Write rules:
  - Channel select ≥ NUM_CH: write ignored.
  - Nibble select 1 with CNT_W=4: write ignored.
  - High-nibble bits above CNT_W-1 are dropped.
  - A held strobe commits once only; another write needs the strobe to fall, then rise again.
- Prescaler: counts 0..PRESCALE-1 and asserts an internal tick when it wraps. PRESCALE=1 gives a tick every clk.
- Counter: cnt advances on each tick and wraps from 2^CNT_W-1 to 0.
- Period boundary (tick while cnt=max):
  - duty_active[i] <= duty_pending[i] for all channels simultaneously.
  - uo_out[7] is high for exactly that clk.
- PWM output: uo_out[i] is registered: (cnt_i < duty_active[i]). Latency is 1 clk from a counter change.
  - duty=0 → constant 0.
  - duty=2^CNT_W-1 → low for 1 tick per period.
- Glitch-free: a write never affects the current period. It appears from the first cnt=0 after the next boundary.
- Simultaneous write commit and boundary on the same edge:
  - active takes the pre-write pending value.
  - The new value applies one period later.

Optional Feature:
- MICROTILE_PWM_PHASE_EN defined: channel i compares against cnt_i = (cnt + i·2^CNT_W/NUM_CH) mod 2^CNT_W. This staggers edges to cut simultaneous switching.
  - Shadow load still happens at the global boundary; the period tick is unchanged.
- Undefined: all channels use cnt and are edge-aligned.

Decomposition:
- Shared package microtile_pkg holds:
  - ui_in field bit-index constants (WR_BIT, NIB_BIT, CH_LSB, DATA_LSB).
  - uo_out TICK_BIT.
  - Parameter-range limits.
- One sub-module, microtile_sync_edge:
  - Parametrised-width 2-FF synchroniser.
  - Rising-edge detect on a selected bit.
  - Same clk/rst.
- Top holds the prescaler, counter, duty register file and comparators.

Test Plan (defaults unless stated, clk checked cycle-accurately):
1. Reset, then write ch0 low=0x0, high=0x4 (duty 0x40) → after the next boundary uo_out[0] is high for 64 of every 256 clk, starting at cnt=0; other channels stay 0. uo_out[7] pulses every 256 clk.
2. Limits: duty 0x00 on ch1 → uo_out[1] constant 0; duty 0xFF on ch2 → uo_out[2] low exactly 1 clk per period.
3. Mid-period write: ch0 at 0x40, then write 0xC0 at cnt=0x80 → current period keeps 64-high; next period after the boundary has 192-high. Repeat with the commit landing exactly on the boundary edge → change is deferred one extra period.
4. Protocol edge cases:
   - Strobe held high for 20 clk → exactly one commit.
   - Channel select 3 with NUM_CH=2 → no register changes.
   - Data changed after commit while strobe still high → ignored.
5. Assert rst at cnt=0x30 with all channels active → uo_out=0 next clk; after release all outputs stay 0 until new writes and a boundary.
6. PRESCALE=3, CNT_W=4, NUM_CH=4, MICROTILE_PWM_PHASE_EN defined, all duties 0x8 → each period is 48 clk. Channel i rising edges are offset by i·4 ticks (12 clk). Without the macro, all four channels have identical waveforms.
